// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
//   INSTR_W   : instruction word width
//   PC_INC    : byte distance between consecutive sequential fetches
//   NOP_INSTR : value the IF/ID instruction field takes while in reset
//   fetch_state_t : fetch FSM states
//     IDLE - one-cycle settle after reset release
//     REQ  - request presented to instruction memory
//     WAIT - request accepted, waiting for read data
//     HOLD - data captured in the hold buffer while decode is stalled
package fetch_pkg;

  localparam int          INSTR_W   = 32;
  localparam int          PC_INC    = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit.sv
// Fetch-side end of branch resolution. Owns the PC, issues one instruction
// memory read at a time, and loads the IF/ID register with the instruction
// and its fetch address + 4. A taken-branch redirect from EX restarts fetch
// at the target and discards any response belonging to the wrong path.
// A one-entry hold buffer absorbs a response that arrives while decode is
// stalled.
//
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   stall_i         : hold IF/ID contents this cycle
//   redirect_valid  : taken branch pulse, redirect_pc is the target
//   imem_req        : read request, imem_addr held stable until imem_ready
//   imem_ready      : request accepted this cycle
//   imem_rvalid     : read data valid, imem_rdata is the instruction word
//   ifid_valid      : IF/ID holds a real instruction
//   ifid_instr      : fetched instruction
//   ifid_pcp4       : fetch address + 4
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pcp4
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  issued_q;
  logic               drop_q, drop_d;
  logic [INSTR_W-1:0] buf_instr_q;
  logic [ADDR_W-1:0]  buf_pcp4_q;

  logic [ADDR_W-1:0]  redirect_tgt;
  logic [ADDR_W-1:0]  issued_pcp4;
  logic               accept;
  logic               resp;
  logic               load_direct;
  logic               load_buf;
  logic               to_buf;

  // Branch targets are forced word aligned; the low two bits are masked off.
  assign redirect_tgt = redirect_pc & ~ADDR_W'(2'b11);
  assign issued_pcp4  = issued_q + INC;

  assign accept = (state_q == REQ) && imem_ready;
  assign resp   = (state_q == WAIT) && imem_rvalid;

  // A redirect kills every load into IF/ID or the buffer in the same cycle.
  assign load_direct = resp && !drop_q && !stall_i && !redirect_valid;
  assign to_buf      = resp && !drop_q &&  stall_i && !redirect_valid;
  assign load_buf    = (state_q == HOLD) && !stall_i && !redirect_valid;

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;

  // Next state, next PC and drop flag. The redirect block at the end
  // overrides the normal transitions.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ready) begin
          pc_d    = pc_q + INC;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          drop_d  = 1'b0;
          state_d = (drop_q || !stall_i) ? REQ : HOLD;
        end
      end
      HOLD: begin
        if (!stall_i) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      pc_d = redirect_tgt;
      if (state_q == REQ && imem_ready) begin
        // The request just accepted belongs to the wrong path.
        drop_d  = 1'b1;
        state_d = WAIT;
      end else if (state_q == WAIT && !imem_rvalid) begin
        // Still owed a wrong-path response; wait for it and throw it away.
        drop_d  = 1'b1;
        state_d = WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = REQ;
      end
    end
  end

  // FSM, PC and issued-address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      issued_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      if (accept) issued_q <= pc_q;
    end
  end

  // One-entry hold buffer for a response that arrives during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_instr_q <= NOP_INSTR;
      buf_pcp4_q  <= '0;
    end else if (redirect_valid) begin
      buf_instr_q <= NOP_INSTR;
      buf_pcp4_q  <= '0;
    end else if (to_buf) begin
      buf_instr_q <= imem_rdata;
      buf_pcp4_q  <= issued_pcp4;
    end
  end

  // IF/ID register. Stall freezes it, an idle unstalled cycle inserts a
  // bubble, a redirect always invalidates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      ifid_pcp4  <= '0;
    end else if (redirect_valid) begin
      ifid_valid <= 1'b0;
    end else if (load_direct) begin
      ifid_valid <= 1'b1;
      ifid_instr <= imem_rdata;
      ifid_pcp4  <= issued_pcp4;
    end else if (load_buf) begin
      ifid_valid <= 1'b1;
      ifid_instr <= buf_instr_q;
      ifid_pcp4  <= buf_pcp4_q;
    end else if (!stall_i) begin
      ifid_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a table of per-cycle vectors for plain
// fetches and redirects, followed by hand-written stall, redirect-under-stall,
// address-wrap and mid-transaction reset sequences.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pcp4;

  int n_vec  = 0;
  int n_miss = 0;

  pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pcp4      (ifid_pcp4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied before an edge, outputs expected just before that edge.
  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pcp4;
  } vec_t;

  vec_t tbl[17];

  task automatic apply_stimulus(input logic st, input logic rd, input logic [31:0] rp,
                                input logic rdy, input logic rv, input logic [31:0] dat);
    stall_i        = st;
    redirect_valid = rd;
    redirect_pc    = rp;
    imem_ready     = rdy;
    imem_rvalid    = rv;
    imem_rdata     = dat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_instr,
                           input logic [31:0] e_pcp4);
    check_output({tag, " req"},   {31'd0, imem_req},   {31'd0, e_req});
    check_output({tag, " addr"},  imem_addr,           e_addr);
    check_output({tag, " valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
    check_output({tag, " instr"}, ifid_instr,          e_instr);
    check_output({tag, " pcp4"},  ifid_pcp4,           e_pcp4);
  endtask

  initial begin
    //              stall redir rpc           rdy rv  rdata          req addr          v  instr          pcp4
    tbl[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h0,   1'b0, 32'h0,        32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2000_0001,1'b0, 32'h4,   1'b0, 32'h0,        32'h0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h4,   1'b1, 32'h2000_0001,32'h4};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h4,   1'b0, 32'h2000_0001,32'h4};
    tbl[5]  = '{1'b0, 1'b1, 32'h40,       1'b0, 1'b0, 32'h0,        1'b0, 32'h8,   1'b0, 32'h2000_0001,32'h4};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h40,  1'b0, 32'h2000_0001,32'h4};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h40,  1'b0, 32'h2000_0001,32'h4};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDEAD_0001,1'b0, 32'h40,  1'b0, 32'h2000_0001,32'h4};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h40,  1'b0, 32'h2000_0001,32'h4};
    tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1111_0040,1'b0, 32'h44,  1'b0, 32'h2000_0001,32'h4};
    tbl[11] = '{1'b0, 1'b1, 32'h8,        1'b0, 1'b0, 32'h0,        1'b1, 32'h44,  1'b1, 32'h1111_0040,32'h44};
    tbl[12] = '{1'b0, 1'b1, 32'h100,      1'b1, 1'b0, 32'h0,        1'b1, 32'h8,   1'b0, 32'h1111_0040,32'h44};
    tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hBAD0_0008,1'b0, 32'h100, 1'b0, 32'h1111_0040,32'h44};
    tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h100, 1'b0, 32'h1111_0040,32'h44};
    tbl[15] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h3333_0100,1'b0, 32'h104, 1'b0, 32'h1111_0040,32'h44};
    tbl[16] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h104, 1'b1, 32'h3333_0100,32'h104};

    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #12;
    check_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    rst_n = 1'b1;

    // Plain fetches, redirect in WAIT, redirect on accept.
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(tbl[i].stall, tbl[i].redir, tbl[i].rpc,
                     tbl[i].ready, tbl[i].rvalid, tbl[i].rdata);
      check_all($sformatf("v%0d", i), tbl[i].e_req, tbl[i].e_addr,
                tbl[i].e_valid, tbl[i].e_instr, tbl[i].e_pcp4);
      tick();
    end

    // Stall arriving with read data: buffered, then loaded after release.
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4444_0104);
    tick();
    check_all("pre_stall", 1'b1, 32'h108, 1'b1, 32'h4444_0104, 32'h108);
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_ABCD);
    tick();
    check_all("stall_rvalid", 1'b0, 32'h10C, 1'b1, 32'h4444_0104, 32'h108);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      check_all($sformatf("hold%0d", k), 1'b0, 32'h10C, 1'b1, 32'h4444_0104, 32'h108);
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check_all("unstall", 1'b1, 32'h10C, 1'b1, 32'h0000_ABCD, 32'h10C);

    // Redirect while stalled still invalidates IF/ID.
    apply_stimulus(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    tick();
    check_all("redir_stall", 1'b1, 32'h200, 1'b0, 32'h0000_ABCD, 32'h10C);

    // Unaligned target near the top of memory, then PC wrap.
    apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'h0);
    tick();
    check_all("top_addr", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_ABCD, 32'h10C);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    check_all("wrap_wait", 1'b0, 32'h0, 1'b0, 32'h0000_ABCD, 32'h10C);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_5555);
    tick();
    check_all("wrap_load", 1'b1, 32'h0, 1'b1, 32'h5555_5555, 32'h0);

    // Reset asserted mid-WAIT, then a stale response after release.
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("mid_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h6666_6666);
    rst_n = 1'b1;
    tick();
    check_all("late_rv0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    check_all("late_rv1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    check_all("post_rst_wait", 1'b0, 32'h4, 1'b0, 32'h0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_7777);
    tick();
    check_all("post_rst_load", 1'b1, 32'h4, 1'b1, 32'h7777_7777, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
